// File: rtl/sram_like_arbiter.sv
// Shares a single sram-like slave port between the instruction-fetch and data-access
// masters, with one outstanding transaction at a time.
module sram_like_arbiter #(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    logic   owner;       // 0 = inst, 1 = data
    logic   last_owner;
    logic   grant;
    logic   in_addr;
    logic   in_data;
    logic   owner_done;

    // On a tie, fixed priority picks data; round-robin picks whoever was not served last.
    always_comb begin
        grant = data_req;
        if (inst_req && data_req) begin
            grant = DATA_PRIORITY ? 1'b1 : ~last_owner;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_req || data_req) begin
                        owner <= grant;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (mem_addr_ok) begin
                        last_owner <= owner;
                        state      <= mem_data_ok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (mem_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);

    // A response only counts once the address phase has been accepted; strays in IDLE are dropped.
    assign owner_done = mem_data_ok && (in_data || (in_addr && mem_addr_ok));

    assign inst_addr_ok = in_addr && !owner && mem_addr_ok;
    assign data_addr_ok = in_addr &&  owner && mem_addr_ok;
    assign inst_data_ok = owner_done && !owner;
    assign data_data_ok = owner_done &&  owner;

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    assign mem_req   = in_addr;
    assign mem_wr    = owner ? data_wr    : inst_wr;
    assign mem_size  = owner ? data_size  : inst_size;
    assign mem_addr  = owner ? data_addr  : inst_addr;
    assign mem_wdata = owner ? data_wdata : 32'd0;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: instance 0 uses fixed data priority,
// instance 1 uses round-robin; a negedge monitor checks both against queued expectations.
module tb_sram_like_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn [2];
    logic        inst_req [2], inst_wr [2], inst_addr_ok [2], inst_data_ok [2];
    logic [1:0]  inst_size [2];
    logic [31:0] inst_addr [2], inst_rdata [2];
    logic        data_req [2], data_wr [2], data_addr_ok [2], data_data_ok [2];
    logic [1:0]  data_size [2];
    logic [31:0] data_addr [2], data_wdata [2], data_rdata [2];
    logic        mem_req [2], mem_wr [2], mem_addr_ok [2], mem_data_ok [2];
    logic [1:0]  mem_size [2];
    logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];
    logic        busy [2];
    logic        stray [2];

    typedef struct {
        logic        own;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_a [2][$];
    txn_t exp_d [2][$];
    int   acc_i [2];
    int   acc_d [2];
    int   done_cnt [2];
    logic prev_hs [2];
    logic last_win [2];
    int   checks = 0;
    int   failures = 0;

    sram_like_arbiter #(.DATA_PRIORITY(1'b1)) u_dp1 (
        .clk(clk), .rstn(rstn[0]),
        .inst_req(inst_req[0]), .inst_wr(inst_wr[0]), .inst_size(inst_size[0]),
        .inst_addr(inst_addr[0]), .inst_rdata(inst_rdata[0]),
        .inst_addr_ok(inst_addr_ok[0]), .inst_data_ok(inst_data_ok[0]),
        .data_req(data_req[0]), .data_wr(data_wr[0]), .data_size(data_size[0]),
        .data_addr(data_addr[0]), .data_wdata(data_wdata[0]), .data_rdata(data_rdata[0]),
        .data_addr_ok(data_addr_ok[0]), .data_data_ok(data_data_ok[0]),
        .mem_req(mem_req[0]), .mem_wr(mem_wr[0]), .mem_size(mem_size[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .mem_addr_ok(mem_addr_ok[0]), .mem_data_ok(mem_data_ok[0]),
        .busy(busy[0])
    );

    sram_like_arbiter #(.DATA_PRIORITY(1'b0)) u_rr (
        .clk(clk), .rstn(rstn[1]),
        .inst_req(inst_req[1]), .inst_wr(inst_wr[1]), .inst_size(inst_size[1]),
        .inst_addr(inst_addr[1]), .inst_rdata(inst_rdata[1]),
        .inst_addr_ok(inst_addr_ok[1]), .inst_data_ok(inst_data_ok[1]),
        .data_req(data_req[1]), .data_wr(data_wr[1]), .data_size(data_size[1]),
        .data_addr(data_addr[1]), .data_wdata(data_wdata[1]), .data_rdata(data_rdata[1]),
        .data_addr_ok(data_addr_ok[1]), .data_data_ok(data_data_ok[1]),
        .mem_req(mem_req[1]), .mem_wr(mem_wr[1]), .mem_size(mem_size[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .mem_addr_ok(mem_addr_ok[1]), .mem_data_ok(mem_data_ok[1]),
        .busy(busy[1])
    );

    function automatic void check(input int u, input string name,
                                  input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL u%0d %s actual=0x%08h required=0x%08h t=%0t", u, name, act, req, $time);
        end
    endfunction

    // Monitor: every slave address accept must hand the expected transaction to its owner,
    // every genuine slave response must return to that owner; nothing else may raise an ok.
    always @(negedge clk) begin
        txn_t t;
        for (int u = 0; u < 2; u++) begin
            if (!rstn[u]) begin
                exp_a[u].delete();
                exp_d[u].delete();
                prev_hs[u] <= 1'b0;
            end else begin
                if (prev_hs[u]) check(u, "mem_req_after_accept", {31'd0, mem_req[u]}, 32'd0);
                prev_hs[u] <= mem_addr_ok[u];
                if (mem_addr_ok[u]) begin
                    if (exp_a[u].size() == 0) begin
                        check(u, "unexpected_addr_accept", 32'd1, 32'd0);
                    end else begin
                        t = exp_a[u].pop_front();
                        check(u, "mem_req", {31'd0, mem_req[u]}, 32'd1);
                        check(u, "mem_addr", mem_addr[u], t.addr);
                        check(u, "mem_wr", {31'd0, mem_wr[u]}, {31'd0, t.wr});
                        check(u, "mem_size", {30'd0, mem_size[u]}, {30'd0, t.size});
                        check(u, "mem_wdata", mem_wdata[u], t.wdata);
                        check(u, "addr_ok_owner", {30'd0, data_addr_ok[u], inst_addr_ok[u]},
                              t.own ? 32'd2 : 32'd1);
                        exp_d[u].push_back(t);
                    end
                end else begin
                    check(u, "addr_ok_quiet", {30'd0, data_addr_ok[u], inst_addr_ok[u]}, 32'd0);
                end
                if (mem_data_ok[u] && !stray[u]) begin
                    if (exp_d[u].size() == 0) begin
                        check(u, "unexpected_data_ok", 32'd1, 32'd0);
                    end else begin
                        t = exp_d[u].pop_front();
                        check(u, "data_ok_owner", {30'd0, data_data_ok[u], inst_data_ok[u]},
                              t.own ? 32'd2 : 32'd1);
                        check(u, "rdata", t.own ? data_rdata[u] : inst_rdata[u], t.rdata);
                        done_cnt[u] <= done_cnt[u] + 1;
                    end
                end else begin
                    check(u, "data_ok_quiet", {30'd0, data_data_ok[u], inst_data_ok[u]}, 32'd0);
                    if (stray[u]) check(u, "stray_busy", {31'd0, busy[u]}, 32'd0);
                end
                if (inst_addr_ok[u]) acc_i[u] <= acc_i[u] + 1;
                if (data_addr_ok[u]) acc_d[u] <= acc_d[u] + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input int f);
        return (f >= 0) ? f : int'($urandom_range(0, 2));
    endfunction

    function automatic txn_t rnd_inst();
        txn_t t;
        t.own   = 1'b0;
        t.wr    = 1'b0;
        t.size  = 2'd2;
        t.addr  = $urandom() & 32'hFFFF_FFFC;
        t.wdata = 32'd0;
        t.rdata = $urandom();
        return t;
    endfunction

    function automatic txn_t rnd_data();
        txn_t t;
        t.own   = 1'b1;
        t.wr    = 1'($urandom_range(0, 1));
        t.size  = 2'($urandom_range(0, 2));
        t.addr  = $urandom();
        t.wdata = $urandom();
        t.rdata = $urandom();
        return t;
    endfunction

    // Model: a tie goes to data on instance 0, and to whoever was not served last on instance 1.
    task automatic do_round(input int u, input logic wi, input logic wd,
                            input txn_t ti, input txn_t td, input int af, input int df);
        txn_t ord [2];
        int   n, served, ad, dd, cyc, ia0, da0, dn0;
        logic pend, dfirst;
        dfirst = (u == 0) ? 1'b1 : ~last_win[u];
        if (wi && wd) begin
            ord[0] = dfirst ? td : ti;
            ord[1] = dfirst ? ti : td;
            n = 2;
        end else begin
            ord[0] = wi ? ti : td;
            ord[1] = ord[0];
            n = 1;
        end
        for (int i = 0; i < n; i++) exp_a[u].push_back(ord[i]);
        last_win[u] = ord[n-1].own;
        ia0 = acc_i[u];
        da0 = acc_d[u];
        dn0 = done_cnt[u];
        inst_req[u] = wi; inst_wr[u] = ti.wr; inst_size[u] = ti.size; inst_addr[u] = ti.addr;
        data_req[u] = wd; data_wr[u] = td.wr; data_size[u] = td.size; data_addr[u] = td.addr;
        data_wdata[u] = td.wdata;
        check(u, "bubble_idle", {31'd0, mem_req[u]}, 32'd0);
        ad = pick(af);
        dd = 0;
        pend = 1'b0;
        served = 0;
        cyc = 0;
        while ((done_cnt[u] - dn0) < n && cyc < 80) begin
            step();
            cyc++;
            if (cyc == 1) check(u, "bubble_grant", {31'd0, mem_req[u]}, 32'd1);
            if (acc_i[u] != ia0) inst_req[u] = 1'b0;
            if (acc_d[u] != da0) data_req[u] = 1'b0;
            mem_addr_ok[u] = 1'b0;
            mem_data_ok[u] = 1'b0;
            if (pend) begin
                if (dd == 0) begin
                    mem_data_ok[u] = 1'b1;
                    mem_rdata[u] = ord[served & 1].rdata;
                    served++;
                    pend = 1'b0;
                end else begin
                    dd--;
                end
            end else if (mem_req[u]) begin
                if (ad == 0) begin
                    mem_addr_ok[u] = 1'b1;
                    ad = pick(af);
                    dd = pick(df);
                    if (dd == 0) begin
                        mem_data_ok[u] = 1'b1;
                        mem_rdata[u] = ord[served & 1].rdata;
                        served++;
                    end else begin
                        pend = 1'b1;
                        dd--;
                    end
                end else begin
                    ad--;
                end
            end
        end
        check(u, "round_completions", done_cnt[u] - dn0, n);
        inst_req[u] = 1'b0;
        data_req[u] = 1'b0;
        mem_addr_ok[u] = 1'b0;
        mem_data_ok[u] = 1'b0;
        repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic check_idle(input int u, input string name);
        check(u, {name, "_busy"}, {31'd0, busy[u]}, 32'd0);
        check(u, {name, "_mem_req"}, {31'd0, mem_req[u]}, 32'd0);
        check(u, {name, "_oks"}, {28'd0, inst_addr_ok[u], inst_data_ok[u],
                                  data_addr_ok[u], data_data_ok[u]}, 32'd0);
    endtask

    initial begin
        txn_t ti, td;
        logic [1:0] pat;
        for (int u = 0; u < 2; u++) begin
            rstn[u] = 1'b0; stray[u] = 1'b0; last_win[u] = 1'b1;
            inst_req[u] = 1'b0; inst_wr[u] = 1'b0; inst_size[u] = 2'd0; inst_addr[u] = 32'd0;
            data_req[u] = 1'b0; data_wr[u] = 1'b0; data_size[u] = 2'd0; data_addr[u] = 32'd0;
            data_wdata[u] = 32'd0; mem_rdata[u] = 32'd0;
            mem_addr_ok[u] = 1'b0; mem_data_ok[u] = 1'b0;
            acc_i[u] = 0; acc_d[u] = 0; done_cnt[u] = 0; prev_hs[u] = 1'b0;
        end
        repeat (2) step();
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        check_idle(0, "reset");
        check_idle(1, "reset");

        // Inst read alone: accept at cycle 1, data at cycle 3.
        ti = rnd_inst();
        ti.addr = 32'hBFC0_0000;
        ti.rdata = 32'h2401_0001;
        do_round(0, 1'b1, 1'b0, ti, rnd_data(), 0, 2);

        // Data store alone.
        td = rnd_data();
        td.wr = 1'b1; td.size = 2'd2; td.addr = 32'h8000_1000; td.wdata = 32'hDEAD_BEEF;
        do_round(0, 1'b0, 1'b1, rnd_inst(), td, -1, -1);

        // Ties under fixed priority, and same-cycle accept+response.
        do_round(0, 1'b1, 1'b1, rnd_inst(), rnd_data(), -1, -1);
        do_round(0, 1'b1, 1'b0, rnd_inst(), rnd_data(), 0, 0);
        do_round(0, 1'b1, 1'b1, rnd_inst(), rnd_data(), 0, 0);

        // Reset while waiting for data, then a stale response lands in IDLE.
        ti = rnd_inst();
        exp_a[0].push_back(ti);
        inst_req[0] = 1'b1; inst_wr[0] = ti.wr; inst_size[0] = ti.size; inst_addr[0] = ti.addr;
        step();
        mem_addr_ok[0] = 1'b1;
        step();
        inst_req[0] = 1'b0;
        mem_addr_ok[0] = 1'b0;
        check(0, "busy_in_data", {31'd0, busy[0]}, 32'd1);
        rstn[0] = 1'b0;
        step();
        rstn[0] = 1'b1;
        last_win[0] = 1'b1;
        check_idle(0, "midreset");
        stray[0] = 1'b1;
        mem_data_ok[0] = 1'b1;
        mem_rdata[0] = $urandom();
        step();
        stray[0] = 1'b0;
        mem_data_ok[0] = 1'b0;
        do_round(0, 1'b1, 1'b0, rnd_inst(), rnd_data(), -1, -1);

        // Round-robin with both requesting: inst, data, inst, data.
        do_round(1, 1'b1, 1'b1, rnd_inst(), rnd_data(), -1, -1);
        do_round(1, 1'b1, 1'b1, rnd_inst(), rnd_data(), -1, -1);

        for (int i = 0; i < 80; i++) begin
            pat = 2'($urandom_range(1, 3));
            do_round(i % 2, pat[0], pat[1], rnd_inst(), rnd_data(), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the pipeline's instruction-fetch requester and its data-access requester.
- Sits between the CPU core (inst/data sram-like masters) and the memory bridge (single sram-like slave).
- Allows exactly one outstanding transaction at a time.
- Selection is fixed data priority or round-robin, set by a parameter.

Parameters:
- DATA_PRIORITY, 1, 1 = data side always wins when both request; 0 = round-robin between inst and data.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- inst_req  in  1  instruction request; held until inst_addr_ok
- inst_wr  in  1  instruction write flag, normally 0
- inst_size  in  2  transfer size
- inst_addr  in  32  instruction address
- inst_rdata  out  32  instruction read data, valid with inst_data_ok
- inst_addr_ok  out  1  instruction address handshake
- inst_data_ok  out  1  instruction data-return pulse
- data_req  in  1  data request; held until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  transfer size
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_rdata  out  32  load data, valid with data_data_ok
- data_addr_ok  out  1  data address handshake
- data_data_ok  out  1  data-return pulse
- mem_req  out  1  slave request
- mem_wr  out  1  slave write flag
- mem_size  out  2  slave transfer size
- mem_addr  out  32  slave address
- mem_wdata  out  32  slave write data
- mem_rdata  in  32  slave read data
- mem_addr_ok  in  1  slave address accepted
- mem_data_ok  in  1  slave data returned / write done
- busy  out  1  1 whenever state is not IDLE

Behaviour:
- States: IDLE, ADDR, DATA. Registers: state, owner (0 = inst, 1 = data), last_owner.
- Reset (rstn = 0 at posedge):
  - state = IDLE, owner = 0, last_owner = 1, so inst wins the first round-robin tie.
  - All ok outputs are 0; mem_req = 0, busy = 0.
- IDLE:
  - mem_req = 0; all ok outputs = 0.
  - If any req is high, owner is loaded and state goes to ADDR at the next edge.
  - Tie with DATA_PRIORITY = 1: owner = data.
  - Tie with DATA_PRIORITY = 0: owner = ~last_owner.
  - Single requester: that requester is granted.
- ADDR:
  - mem_req = 1. mem_wr, mem_size, mem_addr come from the owner; mem_wdata = data_wdata when owner = data, else 0.
  - Owner's addr_ok = mem_addr_ok. Non-owner's addr_ok = 0.
  - On mem_addr_ok: last_owner = owner, state goes to DATA.
  - If mem_addr_ok and mem_data_ok are both 1 in the same cycle:
    - The transaction completes in that cycle; owner's data_ok = 1 and state goes to IDLE.
    - last_owner is still updated.
  - mem_data_ok without mem_addr_ok is ignored.
- DATA:
  - mem_req = 0.
  - Owner's data_ok = mem_data_ok; on mem_data_ok, state goes to IDLE.
  - Non-owner's data_ok = 0.
- Read data: inst_rdata and data_rdata both equal mem_rdata at all times; only the matching data_ok qualifies it.
- Ok outputs are combinational from the slave ok inputs gated by state and owner; all other outputs come from registered state/owner.
- Latency:
  - Request seen in IDLE at cycle 0 gives mem_req at cycle 1 (one bubble).
  - After data_ok, at least one IDLE cycle precedes the next grant.
- Owner is fixed from grant to completion. A new req from the non-owner waits, and is not lost as long as it stays asserted.
- mem_data_ok in IDLE (stray, or a response pending across reset) is ignored; no ok output is asserted.
- Reset mid-transaction: state goes to IDLE immediately. The outstanding response is dropped and the masters re-issue.

Test Plan:
- Inst read alone: inst_req = 1 with addr 0xBFC00000 at cycle 0; slave addr_ok at cycle 1, data_ok at cycle 3 with rdata 0x24010001.
  - Response: mem_req high in cycles 1 only, mem_addr = 0xBFC00000.
  - inst_addr_ok = 1 at cycle 1; inst_data_ok = 1 and inst_rdata = 0x24010001 at cycle 3.
  - data_* ok outputs stay 0 throughout.
- Data store alone: data_req = 1, data_wr = 1, addr 0x80001000, wdata 0xDEADBEEF.
  - Response: mem_wr = 1 and mem_wdata = 0xDEADBEEF while in ADDR; data_data_ok pulses once.
- Simultaneous inst_req and data_req, DATA_PRIORITY = 1: data is served first, then inst.
  - mem_addr sequence: data_addr, then inst_addr; inst_addr_ok stays 0 until data_data_ok.
- DATA_PRIORITY = 0, both requesting continuously for 4 transactions: grants go inst, data, inst, data after reset.
- Slave asserts mem_addr_ok and mem_data_ok in the same cycle: owner's addr_ok and data_ok are both 1 that cycle, and state returns to IDLE at the next edge.
- rstn = 0 for one cycle while in DATA, then mem_data_ok arrives in IDLE: no data_ok is asserted, busy = 0, and a fresh request is granted normally.
